// File: rtl/comar_share_encoder.sv
// Two-share reused-mask encoder: share0 = data ^ mask, share1 = mask, one mask per REUSE_COUNT words.
// Optional macro ENC_ZERO_MASK_REJECT_EN: an all-zero randomness word is consumed but never loaded as mask.
module comar_share_encoder #(
  parameter int WIDTH       = 8,
  parameter int REUSE_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rnd,
  input  logic             rnd_valid,
  output logic             rnd_ready,
  output logic [WIDTH-1:0] share0,
  output logic [WIDTH-1:0] share1,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {FETCH, RUN} state_t;

  localparam logic [7:0] RC = 8'(REUSE_COUNT);

  state_t           r_state;
  logic [WIDTH-1:0] r_mask;
  logic [7:0]       r_use_cnt;
  logic [WIDTH-1:0] r_share0;
  logic [WIDTH-1:0] r_share1;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_rnd_take;
  logic             w_mask_load;
  logic [7:0]       w_cnt_next;

  assign in_ready   = !rst && (r_state == RUN) && (!r_out_valid || out_ready);
  assign rnd_ready  = !rst && (r_state == FETCH);
  assign w_accept   = in_valid && in_ready;
  assign w_rnd_take = rnd_valid && rnd_ready;
  assign w_cnt_next = r_use_cnt + 8'd1;

`ifdef ENC_ZERO_MASK_REJECT_EN
  assign w_mask_load = w_rnd_take && (rnd != '0);
`else
  assign w_mask_load = w_rnd_take;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FETCH;
      r_mask      <= '0;
      r_use_cnt   <= '0;
      r_share0    <= '0;
      r_share1    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      // Output register drains independently of the FSM, so a pending word survives a refresh.
      if (w_accept) begin
        r_share0    <= in_data ^ r_mask;
        r_share1    <= r_mask;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        FETCH: begin
          if (w_mask_load) begin
            r_mask    <= rnd;
            r_use_cnt <= '0;
            r_state   <= RUN;
          end
        end
        RUN: begin
          if (w_accept) begin
            r_use_cnt <= w_cnt_next;
            if (w_cnt_next == RC) r_state <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  assign share0    = r_share0;
  assign share1    = r_share1;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_comar_share_encoder.sv
// Directed bench for comar_share_encoder: REUSE_COUNT=2 instance (a_*) and REUSE_COUNT=1 instance (b_*).
module tb_comar_share_encoder;
  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  logic [7:0] a_in_data, a_rnd, a_share0, a_share1;
  logic       a_in_valid, a_in_ready, a_rnd_valid, a_rnd_ready, a_out_valid, a_out_ready;
  logic [7:0] b_in_data, b_rnd, b_share0, b_share1;
  logic       b_in_valid, b_in_ready, b_rnd_valid, b_rnd_ready, b_out_valid, b_out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  comar_share_encoder #(.WIDTH(8), .REUSE_COUNT(2)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .rnd(a_rnd), .rnd_valid(a_rnd_valid), .rnd_ready(a_rnd_ready),
    .share0(a_share0), .share1(a_share1), .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  comar_share_encoder #(.WIDTH(8), .REUSE_COUNT(1)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .rnd(b_rnd), .rnd_valid(b_rnd_valid), .rnd_ready(b_rnd_ready),
    .share0(b_share0), .share1(b_share1), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  // Inputs change at negedge; one step = the next rising edge, then back to the negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    a_in_valid = 0; a_rnd_valid = 0; a_out_ready = 1; a_in_data = 0; a_rnd = 0;
    b_in_valid = 0; b_rnd_valid = 0; b_out_ready = 1; b_in_data = 0; b_rnd = 0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    a_in_valid = 1; a_rnd_valid = 1; a_out_ready = 1; a_in_data = 8'h12; a_rnd = 8'h34;
    b_in_valid = 0; b_rnd_valid = 0; b_out_ready = 1; b_in_data = 0; b_rnd = 0;
    step();
    #1;
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", a_out_valid); end
    n_tests++; if ({a_share0, a_share1} !== 16'h0000) begin n_fail++; $display("FAIL reset_shares got %h exp 0000", {a_share0, a_share1}); end
    n_tests++; if ({a_in_ready, a_rnd_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_readies got %b exp 00", {a_in_ready, a_rnd_ready}); end
    a_in_valid = 0; a_rnd_valid = 0;
    rst = 1'b0;
    #1;
    n_tests++; if ({a_in_ready, a_rnd_ready} !== 2'b01) begin n_fail++; $display("FAIL post_reset_readies got %b exp 01", {a_in_ready, a_rnd_ready}); end
  endtask

  task automatic test_encode();
    do_reset();
    a_in_valid = 1; a_in_data = 8'h99;     // ignored in FETCH
    #1;
    n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_in_ready got %b exp 0", a_in_ready); end
    a_rnd = 8'h5A; a_rnd_valid = 1; a_in_valid = 0;
    step();
    a_rnd_valid = 0;
    #1;
    n_tests++; if ({a_in_ready, a_rnd_ready} !== 2'b10) begin n_fail++; $display("FAIL run_readies got %b exp 10", {a_in_ready, a_rnd_ready}); end
    a_in_data = 8'h3C; a_in_valid = 1;
    step();
    n_tests++; if ({a_out_valid, a_share0, a_share1} !== {1'b1, 8'h66, 8'h5A}) begin n_fail++; $display("FAIL enc_word0 got %b/%h/%h exp 1/66/5a", a_out_valid, a_share0, a_share1); end
    a_in_data = 8'hFF;
    step();
    n_tests++; if ({a_out_valid, a_share0, a_share1} !== {1'b1, 8'hA5, 8'h5A}) begin n_fail++; $display("FAIL enc_word1 got %b/%h/%h exp 1/a5/5a", a_out_valid, a_share0, a_share1); end
    a_in_valid = 0;
    #1;
    n_tests++; if ({a_in_ready, a_rnd_ready} !== 2'b01) begin n_fail++; $display("FAIL refetch_readies got %b exp 01", {a_in_ready, a_rnd_ready}); end
    a_rnd = 8'h11; a_rnd_valid = 1;
    step();
    a_rnd_valid = 0;
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_out_valid got %b exp 0", a_out_valid); end
    a_in_data = 8'h00; a_in_valid = 1;
    step();
    a_in_valid = 0;
    #1;
    n_tests++; if ({a_out_valid, a_share0, a_share1} !== {1'b1, 8'h11, 8'h11}) begin n_fail++; $display("FAIL enc_new_mask got %b/%h/%h exp 1/11/11", a_out_valid, a_share0, a_share1); end
    n_tests++; if ({a_in_ready, a_rnd_ready} !== 2'b10) begin n_fail++; $display("FAIL cnt_restart got %b exp 10", {a_in_ready, a_rnd_ready}); end
  endtask

  task automatic test_backpressure();
    do_reset();
    a_rnd = 8'h5A; a_rnd_valid = 1;
    step();
    a_rnd_valid = 0; a_in_data = 8'h3C; a_in_valid = 1;
    step();
    a_out_ready = 0; a_in_data = 8'hFF;
    #1;
    n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b exp 0", a_in_ready); end
    step();
    step();
    n_tests++; if ({a_out_valid, a_share0, a_share1} !== {1'b1, 8'h66, 8'h5A}) begin n_fail++; $display("FAIL bp_hold got %b/%h/%h exp 1/66/5a", a_out_valid, a_share0, a_share1); end
    a_out_ready = 1;
    #1;
    n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b exp 1", a_in_ready); end
    step();
    a_in_valid = 0;
    n_tests++; if ({a_out_valid, a_share0, a_share1} !== {1'b1, 8'hA5, 8'h5A}) begin n_fail++; $display("FAIL bp_no_gap got %b/%h/%h exp 1/a5/5a", a_out_valid, a_share0, a_share1); end
    step();
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b exp 0", a_out_valid); end
  endtask

  task automatic test_refresh_stall();
    do_reset();
    b_out_ready = 0;
    b_rnd = 8'h5A; b_rnd_valid = 1;
    step();
    b_rnd_valid = 0; b_in_data = 8'h3C; b_in_valid = 1;
    step();
    b_in_valid = 0;
    #1;
    n_tests++; if ({b_in_ready, b_rnd_ready} !== 2'b01) begin n_fail++; $display("FAIL rc1_fetch got %b exp 01", {b_in_ready, b_rnd_ready}); end
    b_rnd = 8'h77; b_rnd_valid = 1;
    step();
    b_rnd_valid = 0;
    #1;
    n_tests++; if ({b_out_valid, b_share0, b_share1} !== {1'b1, 8'h66, 8'h5A}) begin n_fail++; $display("FAIL stall_refresh_hold got %b/%h/%h exp 1/66/5a", b_out_valid, b_share0, b_share1); end
    n_tests++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got %b exp 0", b_in_ready); end
    b_in_data = 8'h01; b_in_valid = 1;
    step();
    n_tests++; if ({b_share0, b_share1} !== 16'h665A) begin n_fail++; $display("FAIL stall_hold2 got %h/%h exp 66/5a", b_share0, b_share1); end
    b_out_ready = 1;
    step();
    b_in_valid = 0;
    n_tests++; if ({b_out_valid, b_share0, b_share1} !== {1'b1, 8'h76, 8'h77}) begin n_fail++; $display("FAIL stall_new_word got %b/%h/%h exp 1/76/77", b_out_valid, b_share0, b_share1); end
    #1;
    n_tests++; if ({b_in_ready, b_rnd_ready} !== 2'b01) begin n_fail++; $display("FAIL rc1_refetch got %b exp 01", {b_in_ready, b_rnd_ready}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_rnd = 8'h5A; a_rnd_valid = 1;
    step();
    a_rnd_valid = 0; a_in_data = 8'h3C; a_in_valid = 1; a_out_ready = 0;
    step();
    a_in_valid = 0;
    n_tests++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pending got %b exp 1", a_out_valid); end
    rst = 1'b1;
    step();
    #1;
    n_tests++; if ({a_out_valid, a_share0, a_share1} !== 17'h0) begin n_fail++; $display("FAIL mid_reset_out got %b/%h/%h exp 0/00/00", a_out_valid, a_share0, a_share1); end
    n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_in_ready got %b exp 0", a_in_ready); end
    rst = 1'b0;
    #1;
    n_tests++; if ({a_in_ready, a_rnd_ready} !== 2'b01) begin n_fail++; $display("FAIL mid_release got %b exp 01", {a_in_ready, a_rnd_ready}); end
    // New mask after reset must be the fresh one, not the discarded 0x5A.
    a_out_ready = 1; a_rnd = 8'h0F; a_rnd_valid = 1;
    step();
    a_rnd_valid = 0; a_in_data = 8'hF0; a_in_valid = 1;
    step();
    a_in_valid = 0;
    n_tests++; if ({a_share0, a_share1} !== 16'hFF0F) begin n_fail++; $display("FAIL mid_new_mask got %h/%h exp ff/0f", a_share0, a_share1); end
  endtask

  task automatic test_zero_mask();
    do_reset();
    a_rnd = 8'h00; a_rnd_valid = 1;
    step();
`ifdef ENC_ZERO_MASK_REJECT_EN
    #1;
    n_tests++; if ({a_in_ready, a_rnd_ready} !== 2'b01) begin n_fail++; $display("FAIL zero_rejected got %b exp 01", {a_in_ready, a_rnd_ready}); end
    a_rnd = 8'h5A;
    step();
    a_rnd_valid = 0; a_in_data = 8'h3C; a_in_valid = 1;
    step();
    a_in_valid = 0;
    n_tests++; if ({a_out_valid, a_share0, a_share1} !== {1'b1, 8'h66, 8'h5A}) begin n_fail++; $display("FAIL zero_mask_out got %b/%h/%h exp 1/66/5a", a_out_valid, a_share0, a_share1); end
`else
    a_rnd_valid = 0;
    #1;
    n_tests++; if ({a_in_ready, a_rnd_ready} !== 2'b10) begin n_fail++; $display("FAIL zero_accepted got %b exp 10", {a_in_ready, a_rnd_ready}); end
    a_in_data = 8'h3C; a_in_valid = 1;
    step();
    a_in_valid = 0;
    n_tests++; if ({a_out_valid, a_share0, a_share1} !== {1'b1, 8'h3C, 8'h00}) begin n_fail++; $display("FAIL zero_mask_out got %b/%h/%h exp 1/3c/00", a_out_valid, a_share0, a_share1); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 0; a_rnd_valid = 0; a_out_ready = 1; a_in_data = 0; a_rnd = 0;
    b_in_valid = 0; b_rnd_valid = 0; b_out_ready = 1; b_in_data = 0; b_rnd = 0;
    test_reset();
    test_encode();
    test_backpressure();
    test_refresh_stall();
    test_reset_mid();
    test_zero_mask();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/comar_share_encoder.md
Name: comar_share_encoder

Overview:
- Produces the 2-share, reused-mask encoding that COMAR gadgets consume.
- Takes an unmasked data word and one fresh common mask word from the randomness source.
- Emits share0 = data ^ mask and share1 = mask. share1 is the common output share. The same mask is reused for REUSE_COUNT consecutive words before a refresh.
- Sits at the boundary between unmasked input logic and the masked datapath. It is the counterpart to the gadgets' recombination/unmasking side.

Parameters:
- WIDTH, 8, bit width of data, mask and each share.
- REUSE_COUNT, 4, number of words encoded with one common mask before a new mask is fetched. Range 1..255.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  WIDTH  unmasked data word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  encoder accepts in_data this cycle.
- rnd  input  WIDTH  fresh randomness word.
- rnd_valid  input  1  rnd valid.
- rnd_ready  output  1  encoder consumes rnd this cycle.
- share0  output  WIDTH  masked share, data ^ mask.
- share1  output  WIDTH  common output share, equal to mask.
- out_valid  output  1  share0/share1 valid.
- out_ready  input  1  downstream accepts the shares.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - state = FETCH, mask_reg = 0, use_cnt = 0.
  - out_valid = 0, share0 = 0, share1 = 0.
  - in_ready = 0 and rnd_ready = 0 while rst is high.
- State FETCH:
  - rnd_ready = 1, in_ready = 0.
  - On rnd_valid && rnd_ready: mask_reg <= rnd, use_cnt <= 0, state <= RUN.
- State RUN:
  - rnd_ready = 0.
  - in_ready = (!out_valid || out_ready).
  - On in_valid && in_ready (accept):
    - share0 <= in_data ^ mask_reg, share1 <= mask_reg, out_valid <= 1.
    - use_cnt <= use_cnt + 1.
    - If use_cnt + 1 == REUSE_COUNT, state <= FETCH.
- Output register:
  - out_valid clears on out_ready when there is no simultaneous accept.
  - A simultaneous out_ready and accept replaces the output contents in the same edge. Throughput is 1 word/cycle in RUN.
- Latency: exactly 1 cycle from accept to out_valid.
- share0/share1 are register outputs only. There is no combinational path from in_data or rnd to any share output, for glitch isolation at gadget inputs.
- share0 and share1 remain stable while out_valid && !out_ready, including across a mask refresh. Each output holds its own copy of the mask it was encoded with.
- Boundaries:
  - FETCH entered with out_valid pending: the output drains normally, and rnd may be consumed in parallel.
  - REUSE_COUNT = 1: every accepted word is followed by FETCH.
  - in_valid while in FETCH: ignored, in_ready = 0, no data lost.
  - rst mid-operation: all state returns to reset values next edge. Pending output and current mask are discarded.
- mask_reg is never output except via share1 of a word encoded with it.

Optional Feature:
- Macro: ENC_ZERO_MASK_REJECT_EN.
- Defined:
  - In FETCH, a handshaked rnd equal to 0 is consumed (rnd_ready stays 1) but discarded. State stays FETCH.
  - Only a nonzero word loads mask_reg.
- Undefined: any rnd value, including 0, is accepted as mask.

Test Plan:
- WIDTH=8, REUSE_COUNT=2, out_ready=1. rnd=0x5A, then in_data 0x3C, 0xFF back-to-back -> (share0,share1) = (0x66,0x5A), (0xA5,0x5A), each 1 cycle after accept. After the 2nd accept, in_ready=0 and rnd_ready=1.
- Continue: rnd=0x11, in_data 0x00 -> share0=0x11, share1=0x11. use_cnt restarts at 0.
- Backpressure: out_ready=0 after the first output 0x66/0x5A -> output holds 0x66/0x5A, in_ready=0. Raise out_ready together with in_valid on 0xFF -> next cycle 0xA5/0x5A, no gap.
- Refresh under stall: REUSE_COUNT=1, out_ready=0. rnd=0x5A, in 0x3C, then rnd=0x77 -> share1 stays 0x5A until out_ready. The next word 0x01 yields 0x76/0x77.
- Reset mid-stream: assert rst with out_valid=1 -> next cycle out_valid=0, shares 0x00, in_ready=0; after release, rnd_ready=1.
- With ENC_ZERO_MASK_REJECT_EN: rnd 0x00 then 0x5A, in 0x3C -> 0x00 is consumed and ignored, output 0x66/0x5A. Without the macro: output 0x3C/0x00.
